// File: rtl/div_if.sv
// Request/response bundle for the iterative divider: operands and start in,
// status and registered results out.
interface div_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic               is_signed;
   logic [WIDTH-1:0]   dataA;
   logic [WIDTH-1:0]   dataB;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [2*WIDTH-1:0] dout;
   logic               div_zero;

   modport master (
      output start, is_signed, dataA, dataB,
      input  busy, done, quot, rem, dout, div_zero
   );

   modport slave (
      input  start, is_signed, dataA, dataB,
      output busy, done, quot, rem, dout, div_zero
   );
endinterface

// File: rtl/div_unit.sv
// Fixed-latency restoring divider, one quotient bit per clock, with optional
// two's-complement operands and a divide-by-zero flag.
//
// state | meaning
// IDLE  | waiting for start; results from the last division are held
// ITER  | one shift-subtract step per clock, MSB first, WIDTH steps
// FIX   | sign correction and result register update; done pulses after
module div_unit #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input logic  clk,
   input logic  reset,
   div_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   dvs_q;
   logic [WIDTH-1:0]   dvd_raw_q;
   logic               q_neg_q, r_neg_q, zero_q;
   logic [WIDTH-1:0]   quot_q, rem_q;
   logic               done_q, div_zero_q;

   logic               sgn_mode, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH+1:0]   trial;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   q_mag, r_mag, quot_fix, rem_fix;

   assign sgn_mode = SIGNED_EN && bus.is_signed;
   assign a_neg    = sgn_mode && bus.dataA[WIDTH-1];
   assign b_neg    = sgn_mode && bus.dataB[WIDTH-1];
   assign a_mag    = a_neg ? -bus.dataA : bus.dataA;
   assign b_mag    = b_neg ? -bus.dataB : bus.dataB;

   // Upper half plus the next dividend bit is at most WIDTH+1 bits wide;
   // the extra MSB of trial is the borrow that says "does not fit".
   assign trial    = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, dvs_q};
   assign acc_step = trial[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign q_mag    = acc_q[WIDTH-1:0];
   assign r_mag    = acc_q[2*WIDTH-1:WIDTH];
   assign quot_fix = zero_q ? '1 : (q_neg_q ? -q_mag : q_mag);
   assign rem_fix  = zero_q ? dvd_raw_q : (r_neg_q ? -r_mag : r_mag);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = ITER;
         ITER:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         dvs_q      <= '0;
         dvd_raw_q  <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         zero_q     <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= (state_q == FIX);
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  acc_q     <= {{WIDTH{1'b0}}, a_mag};
                  dvs_q     <= b_mag;
                  dvd_raw_q <= bus.dataA;
                  q_neg_q   <= a_neg ^ b_neg;
                  r_neg_q   <= a_neg;
                  zero_q    <= (bus.dataB == '0);
                  cnt_q     <= '0;
               end
            end
            ITER: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CW'(1);
            end
            FIX: begin
               quot_q     <= quot_fix;
               rem_q      <= rem_fix;
               div_zero_q <= zero_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = done_q;
   assign bus.quot     = quot_q;
   assign bus.rem      = rem_q;
   assign bus.dout     = {rem_q, quot_q};
   assign bus.div_zero = div_zero_q;
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal range 4..64.
REQ-002 Parameter: SIGNED_EN, 1, 1 enables two's-complement mode via is_signed; 0 forces unsigned operation regardless of is_signed.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request pulse; sampled only while idle.
REQ-006 Port: is_signed  input  1  operand interpretation for this request; sampled with start.
REQ-007 Port: dataA  input  WIDTH  dividend; sampled with start.
REQ-008 Port: dataB  input  WIDTH  divisor; sampled with start.
REQ-009 Port: busy  output  1  high while a division is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; results valid.
REQ-011 Port: quot  output  WIDTH  quotient.
REQ-012 Port: rem  output  WIDTH  remainder.
REQ-013 Port: dout  output  2*WIDTH  {rem, quot}.
REQ-014 Port: div_zero  output  1  divisor-was-zero flag for the current result.

Function
REQ-015 States SHALL be IDLE, ITER, FIX; the block SHALL power up in IDLE.
REQ-016 IDLE, start=1 at edge k: latch operand magnitudes, result signs, zero flag; iteration counter := 0; go to ITER; busy=1 after edge k.
REQ-017 ITER: one restoring shift-subtract step per edge, MSB first; 2*WIDTH-bit partial remainder; after WIDTH steps (edge k+WIDTH), go to FIX.
REQ-018 FIX, edge k+WIDTH+1: apply sign correction; register quot/rem/dout/div_zero; done=1 for exactly one cycle; busy=0; return to IDLE.
REQ-019 Latency SHALL be fixed at WIDTH+1 cycles from the start edge to done, including the divide-by-zero case.
REQ-020 start while busy=1 SHALL be ignored; in-flight operands are unaffected.
REQ-021 start=1 in the done cycle SHALL be accepted (back-to-back, no idle bubble).
REQ-022 Signed mode: magnitudes divided; quotient negative iff operand signs differ; remainder takes dividend sign; |rem| < |divisor|.
REQ-023 Signed overflow (most-negative / -1): quot = most-negative value, rem = 0, no flag.
REQ-024 Divisor 0: quot = all ones, rem = dividend unchanged (either mode), div_zero = 1.
REQ-025 div_zero SHALL be 0 for every result with a nonzero divisor.
REQ-026 quot, rem, dout, div_zero SHALL hold their values until the next done.
REQ-027 Operand inputs SHALL NOT be required to remain stable after the start edge.

Reset
REQ-028 reset low SHALL immediately force state=IDLE, busy=0, done=0, quot=0, rem=0, dout=0, div_zero=0, and clear internal counters.
REQ-029 Reset mid-operation SHALL abort the division; no done is produced for it.
REQ-030 After reset deasserts, the first start edge SHALL begin a fresh division with full latency.

Verification (WIDTH=32)
REQ-031 Unsigned 100/7, start at edge k -> done at edge k+33; quot=14, rem=2, dout=0x00000002_0000000E, div_zero=0.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; the same operands unsigned -> quot=0x7FFFFFFC, rem=1.
REQ-033 5/0 unsigned and 0xFFFFFFFB/0 signed -> quot=0xFFFFFFFF, rem = dividend, div_zero=1, done at k+33.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0, div_zero=0.
REQ-035 start pulsed at k+5 during busy -> ignored, result of the first operation unchanged; start in the done cycle -> second done exactly 33 cycles later.
REQ-036 reset low at k+10 -> busy=0 and all outputs 0 asynchronously; no done pulse; 9/3 after release -> quot=3, rem=0.
